// File: rtl/instr_mem_pkg.sv
// Shared constants, default program and address helpers for the instruction memory.
package instr_mem_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WIDX_W      = ADDR_W - 2;
  localparam int unsigned DEFAULT_LEN = 5;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  localparam logic [INSTR_W-1:0] DEFAULT_PROG [DEFAULT_LEN] = '{
    32'h2008_0005,
    32'h2009_000A,
    32'h0109_5020,
    32'hAC0A_0000,
    32'h8C0B_0000
  };

  // Byte address to full-width word index; the low two bits select a byte and are dropped.
  function automatic logic [WIDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  // Reset image for word idx: the default program, padded with NOPs.
  function automatic logic [INSTR_W-1:0] default_word(input int unsigned idx);
    logic [INSTR_W-1:0] w;
    w = NOP;
    for (int unsigned i = 0; i < DEFAULT_LEN; i++) begin
      if (idx == i) w = DEFAULT_PROG[3'(i)];
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_addr_decode.sv
// Splits a byte address into a truncated word index, a misalignment flag and a range flag.
module instr_addr_decode
  import instr_mem_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic              misaligned_o,
  output logic              in_range_o
);

  logic [WIDX_W-1:0] full_idx;

  assign full_idx     = word_index(addr_i);
  assign word_idx_o   = full_idx[IDX_W-1:0];
  assign misaligned_o = |addr_i[1:0];
  // In range when no index bit above the memory depth is set.
  assign in_range_o   = (full_idx >> IDX_W) == '0;

endmodule

// File: rtl/instruction_block.sv
// Register-based instruction memory: combinational read by pc, synchronous word write, reset reloads the default program.
module instruction_block
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  output logic               misaligned,
  output logic               out_of_range
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic             wr_misaligned_unused;

  instr_addr_decode #(.IDX_W(IDX_W)) u_rd_decode (
    .addr_i       (pc),
    .word_idx_o   (rd_idx),
    .misaligned_o (misaligned),
    .in_range_o   (rd_in_range)
  );

  instr_addr_decode #(.IDX_W(IDX_W)) u_wr_decode (
    .addr_i       (waddr),
    .word_idx_o   (wr_idx),
    .misaligned_o (wr_misaligned_unused),
    .in_range_o   (wr_in_range)
  );

  // Reset wins over write; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IDX_W'(i)] <= default_word(i);
      end
    end else if (we && wr_in_range) begin
      mem_q[wr_idx] <= wdata;
    end
  end

  assign out_of_range = ~rd_in_range;
  assign instruction  = rd_in_range ? mem_q[rd_idx] : NOP;

endmodule

// File: tb/tb_instruction_block.sv
// Directed bench for instruction_block: table of combinational reads plus write/reset sequences.
`timescale 1ns/1ps
module tb_instruction_block;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        misaligned;
  logic        out_of_range;

  int n_checks;
  int n_fail;

  instruction_block #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instruction  (instruction),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic        oor;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    chk(name, instruction, exp);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; waddr = addr; wdata = data;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; we = 1'b0; pc = '0; waddr = '0; wdata = '0;

    vecs[0]  = '{32'd0,          32'h2008_0005, 1'b0, 1'b0};
    vecs[1]  = '{32'd4,          32'h2009_000A, 1'b0, 1'b0};
    vecs[2]  = '{32'd8,          32'h0109_5020, 1'b0, 1'b0};
    vecs[3]  = '{32'd12,         32'hAC0A_0000, 1'b0, 1'b0};
    vecs[4]  = '{32'd16,         32'h8C0B_0000, 1'b0, 1'b0};
    vecs[5]  = '{32'd20,         32'h0000_0000, 1'b0, 1'b0};
    vecs[6]  = '{4*DEPTH-4,      32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{4*DEPTH,        32'h0000_0000, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFC,  32'h0000_0000, 1'b0, 1'b1};
    vecs[9]  = '{32'd6,          32'h2009_000A, 1'b1, 1'b0};
    vecs[10] = '{32'd15,         32'hAC0A_0000, 1'b1, 1'b0};

    // One-cycle reset loads the default program
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      pc = vecs[i].pc;
      #10;
      chk($sformatf("instr[pc=%0h]", vecs[i].pc), instruction, vecs[i].instr);
      chk($sformatf("mis[pc=%0h]", vecs[i].pc), 32'(misaligned), 32'(vecs[i].mis));
      chk($sformatf("oor[pc=%0h]", vecs[i].pc), 32'(out_of_range), 32'(vecs[i].oor));
    end

    // Write-then-read: old word before the edge, new word after it
    @(negedge clk);
    we = 1'b1; waddr = 32'd8; wdata = 32'hDEAD_BEEF; pc = 32'd8;
    #1;
    chk("wr_before_edge", instruction, 32'h0109_5020);
    @(posedge clk); #1;
    we = 1'b0;
    chk("wr_after_edge", instruction, 32'hDEAD_BEEF);

    // Out-of-range write aliases to word 0 if the range check were missing
    write_word(4*DEPTH, 32'h5555_5555);
    read_chk("oor_wr_word0", 32'd0, 32'h2008_0005);
    read_chk("oor_wr_word2", 32'd8, 32'hDEAD_BEEF);
    read_chk("oor_wr_last",  4*DEPTH-4, 32'h0000_0000);

    // Low address bits of a write are ignored
    write_word(32'd13, 32'hCAFE_F00D);
    read_chk("mis_wr_word3", 32'd12, 32'hCAFE_F00D);
    read_chk("mis_wr_word4", 32'd16, 32'h8C0B_0000);

    // Reset priority over a concurrent write, and it discards loaded words
    write_word(32'd0, 32'h1234_5678);
    read_chk("pre_rst_word0", 32'd0, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b1; we = 1'b1; waddr = 32'd0; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    reset = 1'b0; we = 1'b0;
    read_chk("rst_word0", 32'd0,  32'h2008_0005);
    read_chk("rst_word2", 32'd8,  32'h0109_5020);
    read_chk("rst_word3", 32'd12, 32'hAC0A_0000);
    read_chk("rst_word5", 32'd20, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_block.md
# instruction_block

Word-organized instruction memory for the single-cycle processor datapath. Takes the byte-addressed program counter from the fetch stage and returns the 32-bit instruction at that address combinationally. The memory holds a default program loaded on reset and can be rewritten word by word through a synchronous write port, which is used for program loading.

## Interface

- Clocking: one clock; reset is synchronous and active-high.
- DEPTH, default 256: number of 32-bit instruction words. Must be a power of two, ≥ 8.
- clk, input, 1: rising-edge clock for reset and write.
- reset, input, 1: synchronous, active-high; reloads the default program.
- pc, input, 32: byte address of the instruction to fetch.
- instruction, output, 32: instruction word at `pc`.
- we, input, 1: write enable for program loading.
- waddr, input, 32: byte address of the word to write.
- wdata, input, 32: word to write.
- misaligned, output, 1: `pc[1:0]` is nonzero.
- out_of_range, output, 1: word index of `pc` is at or above DEPTH.

## Operation

- Word index is `pc[31:2]`. The low two bits are ignored for the read; `misaligned` is driven high when they are nonzero.
- In range (`pc[31:2] < DEPTH`): `instruction` equals `mem[pc[31:2]]`.
- Out of range: `instruction` is 32'h0000_0000 (NOP) and `out_of_range` = 1.
- Default program, stored in the package and loaded on reset:
  - word0 = 32'h2008_0005
  - word1 = 32'h2009_000A
  - word2 = 32'h0109_5020
  - word3 = 32'hAC0A_0000
  - word4 = 32'h8C0B_0000
  - all other words = 0
- Write: on a rising clk edge with `we` = 1 and `reset` = 0, `mem[waddr[31:2]]` takes `wdata`.
  - `waddr[1:0]` is ignored.
  - Out-of-range `waddr` is discarded with no effect.
- Reset has priority over write. A write in the same cycle as reset is dropped.

## Timing

- Read path is purely combinational, with zero-cycle latency from `pc` to `instruction`, `misaligned` and `out_of_range`.
  - `instruction` is stable within one propagation delay of a `pc` change, with no clock required.
- Write latency is one edge.
  - Reading the address being written returns the old word until the edge and the new word immediately after it.
- Reset takes effect at the first rising edge with `reset` = 1. Until then, memory contents are undefined.
  - After that edge, `instruction` reflects the default program for the current `pc`.
  - Reset asserted mid-operation discards all previously loaded words.
- Flags have no reset value of their own. They are pure functions of `pc`.
- No handshake; the read is always valid.

## Structure

- Package `instr_mem_pkg`:
  - `INSTR_W` = 32
  - `NOP` = 32'h0
  - default-program constant array and its length, `DEFAULT_LEN` = 5
  - word-index extraction function
- Memory array is implemented as registers, because reset must reinitialize it; no RAM inference is required.
- Natural sub-module: `instr_addr_decode`, which takes a byte address and produces the word index, the misaligned flag and the in-range flag. It is instantiated twice, once for the read port and once for the write port.

## Test plan

- **Default program read:** reset for 1 cycle, then step `pc` = 0, 4, 8, 12, 16 with 10 ns between steps and no clock. Expected:
  - `instruction` = 2008_0005, 2009_000A, 0109_5020, AC0A_0000, 8C0B_0000
  - `misaligned` = 0 and `out_of_range` = 0 throughout
- **Unprogrammed and out-of-range reads:**
  - `pc` = 20 -> `instruction` = 0.
  - `pc` = 4·DEPTH -> `instruction` = 0, `out_of_range` = 1.
  - `pc` = 32'hFFFF_FFFC -> `instruction` = 0, `out_of_range` = 1.
- **Misaligned read:** `pc` = 6 -> `instruction` = 2009_000A, `misaligned` = 1.
- **Write then read:** `we` = 1, `waddr` = 8, `wdata` = DEAD_BEEF, `pc` = 8.
  - Before the edge, `instruction` = 0109_5020.
  - After the edge, it equals DEAD_BEEF.
  - A write to `waddr` = 4·DEPTH changes no word.
- **Reset priority and mid-operation reset:**
  - Write 1234_5678 to address 0, then assert `reset` together with `we` (`wdata` = FFFF_FFFF).
  - After the edge, `pc` = 0 -> 2008_0005.
  - Word at address 8 reads 0109_5020 again.
